meta_info_rom: RTL and testbench

- Read-only metadata block, selectable as design slot 5 behind the chip's multi-project mux.
- Given a project index and a character index on `io_in`, it returns one ASCII character of that project's name string on `io_out[7:0]`.
- Strings are NUL-terminated, so a host can walk `chr_idx` upward until it reads 0x00 and recover every project name.
- Purely combinational lookup followed by one output register.

---
 rtl/meta_info_rom.sv | 96 +++++++++
 tb/tb_meta_info_rom.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/meta_info_rom.sv
// Metadata ROM for the multi-project mux: returns one ASCII character of a project's
// name string per cycle, selected by {proj_idx, chr_idx}, through a single output register.
module meta_info_rom #(
    parameter int NUM_PROJ = 64,
    parameter int SELF_IDX = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [11:0] io_out
);

    localparam logic [6:0] NUM_PROJ_C = 7'(NUM_PROJ);
    localparam logic [5:0] SELF_IDX_C = 6'(SELF_IDX);

    logic [5:0]  chr_idx_s;
    logic [5:0]  proj_idx_s;
    logic [5:0]  tens_s;
    logic [5:0]  ones_s;
    logic [7:0]  char_s;
    logic [11:0] out_d;
    logic [11:0] out_q;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    function automatic logic [7:0] self_char(input logic [5:0] c);
        logic [7:0] ch;
        case (c)
            6'd0:    ch = 8'h6D;
            6'd1:    ch = 8'h65;
            6'd2:    ch = 8'h74;
            6'd3:    ch = 8'h61;
            6'd4:    ch = 8'h5F;
            6'd5:    ch = 8'h69;
            6'd6:    ch = 8'h6E;
            6'd7:    ch = 8'h66;
            6'd8:    ch = 8'h6F;
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    function automatic logic [7:0] proj_char(input logic [5:0] c,
                                             input logic [5:0] tens,
                                             input logic [5:0] ones);
        logic [7:0] ch;
        case (c)
            6'd0:    ch = 8'h70;
            6'd1:    ch = 8'h72;
            6'd2:    ch = 8'h6F;
            6'd3:    ch = 8'h6A;
            6'd4:    ch = 8'h5F;
            6'd5:    ch = 8'h30 + {2'b00, tens};
            6'd6:    ch = 8'h30 + {2'b00, ones};
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    assign chr_idx_s  = io_in[5:0];
    assign proj_idx_s = io_in[11:6];
    assign tens_s     = proj_idx_s / 6'd10;
    assign ones_s     = proj_idx_s % 6'd10;

    // Character lookup for the sampled slot; anything not printable collapses to NUL.
    always_comb begin
        char_s = 8'h00;
        out_d  = 12'h000;
        if (proj_idx_s == SELF_IDX_C) begin
            char_s = self_char(chr_idx_s);
        end else if ({1'b0, proj_idx_s} < NUM_PROJ_C) begin
            char_s = proj_char(chr_idx_s, tens_s, ones_s);
        end else begin
            char_s = 8'h00;
        end
        if (is_printable(char_s)) begin
            out_d = {4'h0, char_s};
        end else begin
            out_d = 12'h000;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= 12'h000;
        end else begin
            out_q <= out_d;
        end
    end

    assign io_out = out_q;

endmodule

// File: tb/tb_meta_info_rom.sv
// Directed bench for meta_info_rom: vector table, reset sequences, and a full index sweep
// against a string-based reference, on a default instance and a NUM_PROJ=8 instance.
module tb_meta_info_rom;

    typedef struct {
        logic [5:0] proj;
        logic [5:0] chr;
        logic [7:0] exp;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [11:0] io_in;
    logic [11:0] io_out;
    logic [11:0] io_out8;

    int tests;
    int fails;
    vec_t vecs[$];

    meta_info_rom dut (
        .clock (clock),
        .reset (reset),
        .io_in (io_in),
        .io_out(io_out)
    );

    meta_info_rom #(.NUM_PROJ(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .io_in (io_in),
        .io_out(io_out8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] model(input int p, input int c, input int np);
        string s;
        if (p == 5) s = "meta_info";
        else if (p < np) s = $sformatf("proj_%02d", p);
        else s = "";
        if (c < s.len()) return s[c];
        return 8'h00;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] p, input logic [5:0] c, input logic rst);
        @(negedge clock);
        reset = rst;
        io_in = {p, c};
    endtask

    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic [5:0] p, input logic [5:0] c, input logic [7:0] e);
        vec_t v;
        v.proj = p;
        v.chr  = c;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [11:0] prev;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        io_in = {6'd5, 6'd0};

        // Reset held for 5 cycles, then first character one edge after release.
        for (int i = 0; i < 5; i++) begin
            drive(6'd5, 6'd0, 1'b1);
            settle();
            check($sformatf("reset_hold_%0d", i), io_out, 12'h000);
        end
        drive(6'd5, 6'd0, 1'b0);
        settle();
        check("first_after_reset", io_out, 12'h06D);

        add(6'd5, 6'd0, 8'h6D); add(6'd5, 6'd1, 8'h65); add(6'd5, 6'd2, 8'h74);
        add(6'd5, 6'd3, 8'h61); add(6'd5, 6'd4, 8'h5F); add(6'd5, 6'd5, 8'h69);
        add(6'd5, 6'd6, 8'h6E); add(6'd5, 6'd7, 8'h66); add(6'd5, 6'd8, 8'h6F);
        add(6'd5, 6'd9, 8'h00);
        add(6'd0, 6'd0, 8'h70); add(6'd0, 6'd1, 8'h72); add(6'd0, 6'd2, 8'h6F);
        add(6'd0, 6'd3, 8'h6A); add(6'd0, 6'd4, 8'h5F); add(6'd0, 6'd5, 8'h30);
        add(6'd0, 6'd6, 8'h30); add(6'd0, 6'd7, 8'h00);
        add(6'd63, 6'd0, 8'h70); add(6'd63, 6'd1, 8'h72); add(6'd63, 6'd2, 8'h6F);
        add(6'd63, 6'd3, 8'h6A); add(6'd63, 6'd4, 8'h5F); add(6'd63, 6'd5, 8'h36);
        add(6'd63, 6'd6, 8'h33); add(6'd63, 6'd7, 8'h00);
        add(6'd12, 6'd0, 8'h70); add(6'd12, 6'd4, 8'h5F); add(6'd12, 6'd5, 8'h31);
        add(6'd12, 6'd6, 8'h32); add(6'd12, 6'd7, 8'h00);
        add(6'd5, 6'd63, 8'h00); add(6'd0, 6'd63, 8'h00); add(6'd37, 6'd5, 8'h33);
        add(6'd37, 6'd6, 8'h37); add(6'd10, 6'd5, 8'h31); add(6'd10, 6'd6, 8'h30);

        // Table vectors, one per cycle; output must not move before the clock edge.
        prev = io_out;
        foreach (vecs[i]) begin
            drive(vecs[i].proj, vecs[i].chr, 1'b0);
            #1;
            check($sformatf("hold_p%0d_c%0d", vecs[i].proj, vecs[i].chr), io_out, prev);
            settle();
            check($sformatf("vec_p%0d_c%0d", vecs[i].proj, vecs[i].chr), io_out,
                  {4'h0, vecs[i].exp});
            prev = io_out;
        end

        // Reduced NUM_PROJ instance: slots 8 and up are empty.
        drive(6'd8, 6'd0, 1'b0);
        settle();
        check("np8_p8", io_out8, 12'h000);
        check("np64_p8", io_out, 12'h070);
        drive(6'd40, 6'd0, 1'b0);
        settle();
        check("np8_p40", io_out8, 12'h000);
        drive(6'd7, 6'd6, 1'b0);
        settle();
        check("np8_p7", io_out8, 12'h037);
        drive(6'd5, 6'd0, 1'b0);
        settle();
        check("np8_p5", io_out8, 12'h06D);

        // Reset in the middle of walking slot 5.
        for (int c = 0; c < 3; c++) begin
            drive(6'd5, 6'(c), 1'b0);
            settle();
        end
        check("walk_c2", io_out, 12'h074);
        drive(6'd5, 6'd3, 1'b1);
        settle();
        check("midwalk_reset", io_out, 12'h000);
        drive(6'd5, 6'd4, 1'b0);
        settle();
        check("after_midwalk", io_out, 12'h05F);

        // Full sweep against the string reference and the output-range property.
        for (int p = 0; p < 64; p++) begin
            for (int c = 0; c < 64; c++) begin
                drive(6'(p), 6'(c), 1'b0);
                settle();
                check($sformatf("sweep_p%0d_c%0d", p, c), io_out, {4'h0, model(p, c, 64)});
                check($sformatf("sweep8_p%0d_c%0d", p, c), io_out8, {4'h0, model(p, c, 8)});
                tests++;
                if (io_out[11:8] != 4'h0 ||
                    !(io_out[7:0] == 8'h00 || (io_out[7:0] >= 8'h20 && io_out[7:0] <= 8'h7E))) begin
                    fails++;
                    $display("FAIL range_p%0d_c%0d: got %03h required ascii or 000", p, c, io_out);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
